bottleneck_n: RTL and testbench

Parametrised, sequenced successor to the 64-to-16-bit bus narrowing bridge. It accepts one master access of 1/2/4/8 bytes on an M_DW-bit bus. Accesses no wider than S_DW are passed to the S_DW-bit slave bus as a single beat. Wider accesses are split into consecutive little-endian beats, and read data is reassembled with sign or zero extension. The block sits between the CPU load/store unit and the narrow external/peripheral bus.

---
 rtl/bottleneck_n.sv | 143 ++++++++++++++
 tb/tb_bottleneck_n.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bottleneck_n.sv
// rtl/bottleneck_n.sv - sequenced M_DW-to-S_DW bus narrowing bridge
module bottleneck_n #(
    parameter int M_DW = 64,
    parameter int S_DW = 16,
    parameter int AW   = 64
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [AW-1:0]   m_adr_i,
    input  logic            m_cyc_i,
    input  logic            m_stb_i,
    input  logic            m_we_i,
    input  logic [1:0]      m_siz_i,
    input  logic            m_signed_i,
    input  logic [M_DW-1:0] m_dat_i,
    output logic            m_ack_o,
    output logic [M_DW-1:0] m_dat_o,
    output logic            m_err_align_o,
    output logic [AW-1:0]   s_adr_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [1:0]      s_siz_o,
    output logic            s_signed_o,
    output logic [S_DW-1:0] s_dat_o,
    input  logic            s_ack_i,
    input  logic [S_DW-1:0] s_dat_i
);
    localparam int         SB  = S_DW / 8;
    localparam int         LSB = $clog2(SB);
    localparam logic [1:0] BSZ = 2'(LSB);

    typedef enum logic [1:0] {IDLE, BEAT, ACK} state_t;

    state_t          state;
    logic [AW-1:0]   r_adr;
    logic [1:0]      r_siz;
    logic            r_we;
    logic            r_signed;
    logic [M_DW-1:0] r_dat;
    logic [M_DW-1:0] rbuf;
    logic [2:0]      k;

    logic [2:0]      amask;
    logic [1:0]      beat_siz;
    logic [2:0]      nb_last;
    logic [M_DW-1:0] size_mask;
    logic            top_bit;
    logic [8:0]      sh;
    logic            in_beat;

    // Alignment mask of the live request and the misalignment flag
    always_comb begin
        case (m_siz_i)
            2'd0:    amask = 3'b000;
            2'd1:    amask = 3'b001;
            2'd2:    amask = 3'b011;
            default: amask = 3'b111;
        endcase
    end

    assign m_err_align_o = m_cyc_i & m_stb_i & (|(m_adr_i[2:0] & amask));

    // Beat size and last beat index; accesses no wider than the slave bus take one beat
    always_comb begin
        if (r_siz > BSZ) begin
            beat_siz = BSZ;
            nb_last  = 3'((1 << (r_siz - BSZ)) - 1);
        end else begin
            beat_siz = r_siz;
            nb_last  = 3'd0;
        end
    end

    // Valid-byte mask of the latched access and the sign bit of the assembled value
    always_comb begin
        case (r_siz)
            2'd0: begin size_mask = M_DW'(64'h0000_0000_0000_00ff); top_bit = rbuf[7];  end
            2'd1: begin size_mask = M_DW'(64'h0000_0000_0000_ffff); top_bit = rbuf[15]; end
            2'd2: begin size_mask = M_DW'(64'h0000_0000_ffff_ffff); top_bit = rbuf[31]; end
            default: begin size_mask = '1; top_bit = rbuf[M_DW-1]; end
        endcase
    end

    assign sh      = 9'(k) * 9'(S_DW);
    assign in_beat = (state == BEAT);

    assign s_cyc_o    = in_beat & m_cyc_i;
    assign s_stb_o    = in_beat & m_cyc_i;
    assign s_we_o     = in_beat & r_we;
    assign s_signed_o = in_beat & r_signed;
    assign s_siz_o    = in_beat ? beat_siz : 2'd0;
    assign s_adr_o    = in_beat ? (r_adr + (AW'(k) << LSB)) : '0;
    assign s_dat_o    = in_beat ? S_DW'(r_dat >> sh) : '0;
    assign m_ack_o    = (state == ACK);

    // Extension follows m_signed_i live so the master may reinterpret after ack
    assign m_dat_o = rbuf | ((m_signed_i & top_bit) ? ~size_mask : '0);

    // Transfer sequencer: accept, step beats, pulse ack
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state    <= IDLE;
            r_adr    <= '0;
            r_siz    <= 2'd0;
            r_we     <= 1'b0;
            r_signed <= 1'b0;
            r_dat    <= '0;
            rbuf     <= '0;
            k        <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (m_cyc_i && m_stb_i && !m_err_align_o) begin
                        r_adr    <= m_adr_i;
                        r_siz    <= m_siz_i;
                        r_we     <= m_we_i;
                        r_signed <= m_signed_i;
                        r_dat    <= m_dat_i;
                        rbuf     <= '0;
                        k        <= 3'd0;
                        state    <= BEAT;
                    end
                end
                BEAT: begin
                    if (!m_cyc_i) begin
                        state <= IDLE;
                    end else if (s_ack_i) begin
                        if (!r_we) begin
                            rbuf <= rbuf | ((M_DW'(s_dat_i) << sh) & size_mask);
                        end
                        if (k == nb_last) begin
                            state <= ACK;
                        end else begin
                            k <= k + 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bottleneck_n.sv
// tb/tb_bottleneck_n.sv - scoreboard bench for bottleneck_n at S_DW 16 and 32
module tb_bottleneck_n;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_i = 1'b1;
    logic [63:0] m_adr = '0;
    logic        m_cyc = 1'b0, m_stb = 1'b0, m_we = 1'b0, m_signed = 1'b0;
    logic [1:0]  m_siz = 2'd0;
    logic [63:0] m_wd = '0;
    logic        sel32 = 1'b0;
    logic        force_ack = 1'b0;

    logic        m_ack16, err16, s_cyc16, s_stb16, s_we16, s_sgn16;
    logic [63:0] m_rd16, s_adr16;
    logic [1:0]  s_siz16;
    logic [15:0] s_wd16;
    logic        s_ack16 = 1'b0;
    logic [15:0] s_rd16 = '0;

    logic        m_ack32, err32, s_cyc32, s_stb32, s_we32, s_sgn32;
    logic [63:0] m_rd32, s_adr32;
    logic [1:0]  s_siz32;
    logic [31:0] s_wd32;
    logic        s_ack32 = 1'b0;
    logic [31:0] s_rd32 = '0;

    bottleneck_n #(.M_DW(64), .S_DW(16), .AW(64)) dut16 (
        .clk_i(clk), .reset_i(reset_i), .m_adr_i(m_adr), .m_cyc_i(m_cyc & ~sel32),
        .m_stb_i(m_stb & ~sel32), .m_we_i(m_we), .m_siz_i(m_siz), .m_signed_i(m_signed),
        .m_dat_i(m_wd), .m_ack_o(m_ack16), .m_dat_o(m_rd16), .m_err_align_o(err16),
        .s_adr_o(s_adr16), .s_cyc_o(s_cyc16), .s_stb_o(s_stb16), .s_we_o(s_we16),
        .s_siz_o(s_siz16), .s_signed_o(s_sgn16), .s_dat_o(s_wd16),
        .s_ack_i(s_ack16 | force_ack), .s_dat_i(s_rd16)
    );

    bottleneck_n #(.M_DW(64), .S_DW(32), .AW(64)) dut32 (
        .clk_i(clk), .reset_i(reset_i), .m_adr_i(m_adr), .m_cyc_i(m_cyc & sel32),
        .m_stb_i(m_stb & sel32), .m_we_i(m_we), .m_siz_i(m_siz), .m_signed_i(m_signed),
        .m_dat_i(m_wd), .m_ack_o(m_ack32), .m_dat_o(m_rd32), .m_err_align_o(err32),
        .s_adr_o(s_adr32), .s_cyc_o(s_cyc32), .s_stb_o(s_stb32), .s_we_o(s_we32),
        .s_siz_o(s_siz32), .s_signed_o(s_sgn32), .s_dat_o(s_wd32),
        .s_ack_i(s_ack32), .s_dat_i(s_rd32)
    );

    int n_pass = 0;
    int n_total = 0;

    logic [7:0]  mem [logic [63:0]];
    logic [63:0] exp_q [$];

    typedef struct packed {
        logic [63:0] adr;
        logic [1:0]  siz;
        logic [15:0] dat;
    } beat_t;
    beat_t exp_beat_q [$];
    beat_t got_beat;
    beat_t want_beat;

    int         wait_cfg = 0;
    int         waited16 = 0, xb16 = 0, beats16 = 0;
    int         waited32 = 0, xb32 = 0, beats32 = 0;
    logic [1:0] last_siz16 = '0, last_siz32 = '0;

    function automatic logic [7:0] rd_byte(input logic [63:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ 8'h5a;
    endfunction

    function automatic logic [63:0] exp_read(input logic [63:0] a, input logic [1:0] siz, input logic sgn);
        logic [63:0] v;
        int nbytes;
        v = '0;
        nbytes = 1 << siz;
        for (int i = 0; i < nbytes; i++) v[i*8 +: 8] = rd_byte(a + 64'(i));
        if (sgn && v[nbytes*8-1])
            for (int i = nbytes * 8; i < 64; i++) v[i] = 1'b1;
        return v;
    endfunction

    // 16-bit slave: waits wait_cfg cycles on the first beat only, then acks each beat
    always @(posedge clk) begin
        #1;
        if (s_cyc16 !== 1'b1) begin
            s_ack16  = 1'b0;
            waited16 = 0;
            xb16     = 0;
        end else if (xb16 == 0 && waited16 < wait_cfg) begin
            s_ack16  = 1'b0;
            waited16++;
        end else begin
            s_ack16 = 1'b1;
            xb16++;
            beats16++;
            last_siz16 = s_siz16;
            for (int i = 0; i < 2; i++) s_rd16[i*8 +: 8] = rd_byte(s_adr16 + 64'(i));
            if (s_we16) begin
                for (int i = 0; i < (1 << s_siz16); i++) mem[s_adr16 + 64'(i)] = s_wd16[i*8 +: 8];
                if (exp_beat_q.size() > 0) begin
                    want_beat = exp_beat_q.pop_front();
                    got_beat  = '{adr: s_adr16, siz: s_siz16, dat: s_wd16};
                    n_total++;
                    if (got_beat !== want_beat)
                        $display("FAIL write_beat: got adr=%h siz=%0d dat=%h, expected adr=%h siz=%0d dat=%h",
                                 got_beat.adr, got_beat.siz, got_beat.dat, want_beat.adr, want_beat.siz, want_beat.dat);
                    else n_pass++;
                end
            end
        end
    end

    // 32-bit slave, same policy
    always @(posedge clk) begin
        #1;
        if (s_cyc32 !== 1'b1) begin
            s_ack32  = 1'b0;
            waited32 = 0;
            xb32     = 0;
        end else if (xb32 == 0 && waited32 < wait_cfg) begin
            s_ack32  = 1'b0;
            waited32++;
        end else begin
            s_ack32 = 1'b1;
            xb32++;
            beats32++;
            last_siz32 = s_siz32;
            for (int i = 0; i < 4; i++) s_rd32[i*8 +: 8] = rd_byte(s_adr32 + 64'(i));
            if (s_we32)
                for (int i = 0; i < (1 << s_siz32); i++) mem[s_adr32 + 64'(i)] = s_wd32[i*8 +: 8];
        end
    end

    task automatic start(input logic s32, input logic [63:0] a, input logic [1:0] siz,
                         input logic we, input logic sgn, input logic [63:0] d);
        @(negedge clk);
        sel32 = s32; m_adr = a; m_siz = siz; m_we = we; m_signed = sgn; m_wd = d;
        m_cyc = 1'b1; m_stb = 1'b1;
        if (!we) exp_q.push_back(exp_read(a, siz, sgn));
    endtask

    task automatic wait_ack(output int cycles);
        logic seen;
        cycles = 0;
        seen = 1'b0;
        while (!seen && cycles < 60) begin
            @(posedge clk); #1;
            cycles++;
            seen = sel32 ? m_ack32 : m_ack16;
        end
    endtask

    task automatic drop_req();
        @(negedge clk);
        m_cyc = 1'b0; m_stb = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if ({s_cyc16, s_stb16, s_we16, s_sgn16, s_siz16, s_adr16, s_wd16} !== '0)
            $display("FAIL reset_s16: got cyc=%b adr=%h dat=%h, expected all zero", s_cyc16, s_adr16, s_wd16);
        else n_pass++;
        n_total++;
        if (m_ack16 !== 1'b0 || m_rd16 !== 64'h0)
            $display("FAIL reset_m16: got ack=%b dat=%h, expected 0/0", m_ack16, m_rd16);
        else n_pass++;
        n_total++;
        if ({s_cyc32, s_adr32, s_wd32, m_ack32, m_rd32} !== '0)
            $display("FAIL reset_32: got cyc=%b ack=%b dat=%h, expected zero", s_cyc32, m_ack32, m_rd32);
        else n_pass++;
        @(negedge clk);
        reset_i = 1'b0;
    endtask

    task automatic test_byte_read();
        int cyc;
        logic [63:0] e;
        mem[64'h1111] = 8'haa;
        wait_cfg = 1; beats16 = 0;
        start(1'b0, 64'h1111, 2'd0, 1'b0, 1'b1, '0);
        wait_ack(cyc);
        e = exp_q.pop_front();
        n_total++;
        if (cyc !== 3) $display("FAIL byte_latency: got %0d cycles, expected 3", cyc); else n_pass++;
        n_total++;
        if (m_rd16 !== e) $display("FAIL byte_signed: got %h expected %h", m_rd16, e); else n_pass++;
        n_total++;
        if (beats16 !== 1 || last_siz16 !== 2'd0)
            $display("FAIL byte_beats: got %0d beats siz %0d, expected 1 beat siz 0", beats16, last_siz16);
        else n_pass++;
        @(negedge clk);
        m_cyc = 1'b0; m_stb = 1'b0; m_signed = 1'b0;
        #1;
        e = exp_read(64'h1111, 2'd0, 1'b0);
        n_total++;
        if (m_rd16 !== e) $display("FAIL byte_unsigned: got %h expected %h", m_rd16, e); else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (m_ack16 !== 1'b0) $display("FAIL byte_ack_pulse: got ack=%b expected 0", m_ack16); else n_pass++;
    endtask

    task automatic test_misalign();
        int bad;
        int cyc;
        logic [63:0] e;
        @(negedge clk);
        sel32 = 1'b0; m_adr = 64'h1111; m_siz = 2'd1; m_we = 1'b0; m_signed = 1'b1;
        m_cyc = 1'b1; m_stb = 1'b1; force_ack = 1'b1;
        #1;
        n_total++;
        if (err16 !== 1'b1) $display("FAIL misalign_flag: got %b expected 1", err16); else n_pass++;
        bad = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (s_cyc16 !== 1'b0 || m_ack16 !== 1'b0) bad++;
        end
        n_total++;
        if (bad !== 0) $display("FAIL misalign_quiet: got %0d active cycles expected 0", bad); else n_pass++;
        @(negedge clk);
        m_cyc = 1'b0; m_stb = 1'b0; force_ack = 1'b0;
        mem[64'h1112] = 8'h55; mem[64'h1113] = 8'haa;
        wait_cfg = 0;
        start(1'b0, 64'h1112, 2'd1, 1'b0, 1'b1, '0);
        #1;
        n_total++;
        if (err16 !== 1'b0) $display("FAIL aligned_flag: got %b expected 0", err16); else n_pass++;
        wait_ack(cyc);
        e = exp_q.pop_front();
        n_total++;
        if (m_rd16 !== e || cyc !== 2)
            $display("FAIL hword_read: got %h in %0d cycles expected %h in 2", m_rd16, cyc, e);
        else n_pass++;
        drop_req();
    endtask

    task automatic test_dword_write();
        int cyc;
        logic [63:0] d;
        logic [63:0] back;
        d = 64'haaaa_bbbb_cccc_dddd;
        wait_cfg = 0; beats16 = 0;
        exp_beat_q.push_back('{adr: 64'h1110, siz: 2'd1, dat: 16'hdddd});
        exp_beat_q.push_back('{adr: 64'h1112, siz: 2'd1, dat: 16'hcccc});
        exp_beat_q.push_back('{adr: 64'h1114, siz: 2'd1, dat: 16'hbbbb});
        exp_beat_q.push_back('{adr: 64'h1116, siz: 2'd1, dat: 16'haaaa});
        start(1'b0, 64'h1110, 2'd3, 1'b1, 1'b0, d);
        wait_ack(cyc);
        n_total++;
        if (cyc !== 5) $display("FAIL dword_latency: got %0d cycles expected 5", cyc); else n_pass++;
        n_total++;
        if (beats16 !== 4 || exp_beat_q.size() !== 0)
            $display("FAIL dword_beats: got %0d beats, %0d unmatched, expected 4/0", beats16, exp_beat_q.size());
        else n_pass++;
        drop_req();
        back = exp_read(64'h1110, 2'd3, 1'b0);
        n_total++;
        if (back !== d) $display("FAIL dword_mem: got %h expected %h", back, d); else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (m_ack16 !== 1'b0) $display("FAIL dword_ack_pulse: got ack=%b expected 0", m_ack16); else n_pass++;
    endtask

    task automatic test_word_read_waits();
        int cyc;
        int acks;
        logic [63:0] e;
        mem[64'h1114] = 8'h78; mem[64'h1115] = 8'h56;
        mem[64'h1116] = 8'h34; mem[64'h1117] = 8'h92;
        wait_cfg = 2;
        start(1'b0, 64'h1114, 2'd2, 1'b0, 1'b1, '0);
        wait_ack(cyc);
        e = exp_q.pop_front();
        n_total++;
        if (m_rd16 !== e || e !== 64'hffff_ffff_9234_5678)
            $display("FAIL word_read: got %h expected %h", m_rd16, 64'hffff_ffff_9234_5678);
        else n_pass++;
        n_total++;
        if (cyc !== 5) $display("FAIL word_latency: got %0d cycles expected 5", cyc); else n_pass++;
        drop_req();
        acks = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (m_ack16) acks++;
        end
        n_total++;
        if (acks !== 0) $display("FAIL word_ack_pulse: got %0d extra acks expected 0", acks); else n_pass++;
        wait_cfg = 0;
    endtask

    task automatic test_s32();
        int cyc;
        logic [63:0] e;
        mem[64'h1118] = 8'h44; mem[64'h1119] = 8'h33; mem[64'h111a] = 8'h22; mem[64'h111b] = 8'h11;
        mem[64'h111c] = 8'h88; mem[64'h111d] = 8'h77; mem[64'h111e] = 8'h66; mem[64'h111f] = 8'h55;
        wait_cfg = 0; beats32 = 0;
        start(1'b1, 64'h1118, 2'd3, 1'b0, 1'b1, '0);
        wait_ack(cyc);
        e = exp_q.pop_front();
        n_total++;
        if (m_rd32 !== e || e !== 64'h5566_7788_1122_3344)
            $display("FAIL s32_dword: got %h expected %h", m_rd32, 64'h5566_7788_1122_3344);
        else n_pass++;
        n_total++;
        if (beats32 !== 2 || cyc !== 3)
            $display("FAIL s32_beats: got %0d beats in %0d cycles expected 2 in 3", beats32, cyc);
        else n_pass++;
        drop_req();
        beats32 = 0;
        start(1'b1, 64'h111b, 2'd0, 1'b0, 1'b0, '0);
        wait_ack(cyc);
        e = exp_q.pop_front();
        n_total++;
        if (m_rd32 !== e) $display("FAIL s32_byte: got %h expected %h", m_rd32, e); else n_pass++;
        n_total++;
        if (beats32 !== 1 || last_siz32 !== 2'd0 || cyc !== 2)
            $display("FAIL s32_byte_beat: got %0d beats siz %0d in %0d cycles expected 1/0/2", beats32, last_siz32, cyc);
        else n_pass++;
        drop_req();
        sel32 = 1'b0;
    endtask

    task automatic test_abort();
        int acks;
        wait_cfg = 0;
        start(1'b0, 64'h1120, 2'd3, 1'b0, 1'b0, '0);
        void'(exp_q.pop_back());
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        m_cyc = 1'b0;
        #1;
        n_total++;
        if (s_cyc16 !== 1'b0) $display("FAIL abort_scyc: got %b expected 0", s_cyc16); else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (m_ack16 !== 1'b0) $display("FAIL abort_ack: got %b expected 0", m_ack16); else n_pass++;
        @(negedge clk);
        m_cyc = 1'b1; m_stb = 1'b0;
        #1;
        n_total++;
        if (s_cyc16 !== 1'b0) $display("FAIL abort_idle: got s_cyc=%b expected 0", s_cyc16); else n_pass++;
        acks = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (m_ack16 || s_cyc16) acks++;
        end
        n_total++;
        if (acks !== 0) $display("FAIL abort_quiet: got %0d active cycles expected 0", acks); else n_pass++;
        drop_req();
    endtask

    task automatic test_reset_mid();
        start(1'b0, 64'h1128, 2'd3, 1'b0, 1'b1, '0);
        void'(exp_q.pop_back());
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        reset_i = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if ({s_cyc16, s_stb16, s_we16, s_sgn16, s_siz16, s_adr16, s_wd16} !== '0)
            $display("FAIL midreset_s: got cyc=%b adr=%h siz=%0d expected zero", s_cyc16, s_adr16, s_siz16);
        else n_pass++;
        n_total++;
        if (m_ack16 !== 1'b0 || m_rd16 !== 64'h0)
            $display("FAIL midreset_m: got ack=%b dat=%h expected 0/0", m_ack16, m_rd16);
        else n_pass++;
        @(negedge clk);
        reset_i = 1'b0; m_cyc = 1'b0; m_stb = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if (s_cyc16 !== 1'b0 || m_ack16 !== 1'b0)
            $display("FAIL midreset_idle: got cyc=%b ack=%b expected 0/0", s_cyc16, m_ack16);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_byte_read();
        test_misalign();
        test_dword_write();
        test_word_read_waits();
        test_s32();
        test_abort();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
